tile_pattern_gen: RTL and testbench

Game-logic stage that feeds the tile address generator. Holds the 5-row x 3-column black/white tile map (z0..z14) and refills each row from an LFSR when that row scrolls off the bottom. Judges key presses against the bottom row, keeps the score and flags misses. Advances on the same scroll tick that moves the tile rows in the address generator.

---
 rtl/tile_pkg.sv | 34 +++
 rtl/tile_lfsr.sv | 27 ++
 rtl/tile_pattern_gen.sv | 151 +++++++++++++++
 tb/tb_tile_pattern_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the tile game-logic stage: game state codes, map geometry,
// FSM encoding and the LFSR-to-column mapping.
package tile_pkg;

    localparam int ROWS = 5;
    localparam int COLS = 3;

    localparam logic [2:0] GS_IDLE  = 3'b000;
    localparam logic [2:0] GS_PLAY  = 3'b001;
    localparam logic [2:0] GS_STOP  = 3'b010;
    localparam logic [2:0] GS_SCORE = 3'b011;
    localparam logic [2:0] GS_SPEED = 3'b100;
    localparam logic [2:0] GS_MISS  = 3'b101;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_LOAD = 2'd1,
        FSM_RUN  = 2'd2,
        FSM_OVER = 2'd3
    } fsm_t;

    // Code 11 doubles up on the middle column so every pattern is one-hot.
    function automatic logic [COLS-1:0] col_map(input logic [1:0] sel);
        logic [COLS-1:0] pat;
        case (sel)
            2'b00:   pat = 3'b001;
            2'b01:   pat = 3'b010;
            2'b10:   pat = 3'b100;
            default: pat = 3'b010;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/tile_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) and its one-hot column mapper.
import tile_pkg::*;

module tile_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    output logic [COLS-1:0] o_pattern
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign o_pattern = col_map(r_lfsr[1:0]);

endmodule

// File: rtl/tile_pattern_gen.sv
// Tile map, hit/miss judge and score for the scrolling tile game. Everything advances
// on the scroll tick shared with the address generator; o_dbg_fsm exposes the FSM.
import tile_pkg::*;

module tile_pattern_gen #(
    parameter int         ROW_H     = 96,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         SCORE_MAX = 999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           state,
    input  logic                 scroll_tick,
    input  logic [COLS-1:0]      key,
    output logic [ROWS*COLS-1:0] tiles,
    output logic [2:0]           bottom_slot,
    output logic [9:0]           score,
    output logic                 game_over,
    output logic                 miss,
    output fsm_t                 o_dbg_fsm
);

    localparam int              TW        = (ROW_H > 1) ? $clog2(ROW_H) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(ROW_H - 1);
    localparam logic [9:0]      SMAX      = 10'(SCORE_MAX);
    localparam logic [2:0]      LAST_SLOT = 3'(ROWS - 1);

    fsm_t             r_fsm,    w_fsm;
    logic [COLS-1:0]  r_slot    [ROWS];
    logic [COLS-1:0]  w_slot    [ROWS];
    logic [2:0]       r_bottom, w_bottom;
    logic [TW-1:0]    r_tick,   w_tick;
    logic [9:0]       r_score,  w_score;
    logic             r_over,   w_over;
    logic             r_miss,   w_miss;
    logic [2:0]       r_load,   w_load;

    logic [COLS-1:0]  w_pat;
    logic [COLS-1:0]  w_bpat;
    logic             w_hit;
    logic             w_exit;

    tile_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .o_pattern (w_pat)
    );

    assign w_bpat = r_slot[r_bottom];
    assign w_hit  = (key == w_bpat) && (w_bpat != '0);
    assign w_exit = scroll_tick && (r_tick == TICK_LAST);

    always_comb begin
        w_fsm    = r_fsm;
        w_slot   = r_slot;
        w_bottom = r_bottom;
        w_tick   = r_tick;
        w_score  = r_score;
        w_over   = r_over;
        w_miss   = 1'b0;
        w_load   = r_load;

        case (r_fsm)
            FSM_IDLE: begin
                for (int s = 0; s < ROWS; s++) w_slot[s] = '0;
                w_load = 3'd0;
                if (state == GS_PLAY) w_fsm = FSM_LOAD;
            end
            FSM_LOAD: begin
                w_slot[r_load] = w_pat;
                w_score        = '0;
                w_tick         = '0;
                w_bottom       = 3'd0;
                if (r_load == LAST_SLOT) w_fsm = FSM_RUN;
                else                     w_load = r_load + 3'd1;
            end
            FSM_RUN: begin
                if (state == GS_IDLE) begin
                    w_fsm = FSM_IDLE;
                    for (int s = 0; s < ROWS; s++) w_slot[s] = '0;
                end else if (state == GS_PLAY) begin
                    // The key is judged against the pre-exit slot contents.
                    if ((|key) && !w_hit) begin
                        w_miss = 1'b1;
                    end else begin
                        if (w_hit) begin
                            w_slot[r_bottom] = '0;
                            if (r_score < SMAX) w_score = r_score + 10'd1;
                        end
                        if (w_exit) begin
                            if (!w_hit && (w_bpat != '0)) begin
                                w_miss = 1'b1;
                            end else begin
                                w_slot[r_bottom] = w_pat;
                                w_bottom = (r_bottom == LAST_SLOT) ? 3'd0 : r_bottom + 3'd1;
                                w_tick   = '0;
                            end
                        end else if (scroll_tick) begin
                            w_tick = r_tick + 1'b1;
                        end
                    end
                    if (w_miss) begin
                        w_fsm  = FSM_OVER;
                        w_over = 1'b1;
                    end
                end
            end
            FSM_OVER: begin
                if (state == GS_IDLE) begin
                    w_fsm  = FSM_IDLE;
                    w_over = 1'b0;
                    for (int s = 0; s < ROWS; s++) w_slot[s] = '0;
                end
            end
            default: w_fsm = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm    <= FSM_IDLE;
            for (int s = 0; s < ROWS; s++) r_slot[s] <= '0;
            r_bottom <= 3'd0;
            r_tick   <= '0;
            r_score  <= '0;
            r_over   <= 1'b0;
            r_miss   <= 1'b0;
            r_load   <= 3'd0;
        end else begin
            r_fsm    <= w_fsm;
            r_slot   <= w_slot;
            r_bottom <= w_bottom;
            r_tick   <= w_tick;
            r_score  <= w_score;
            r_over   <= w_over;
            r_miss   <= w_miss;
            r_load   <= w_load;
        end
    end

    for (genvar s = 0; s < ROWS; s++) begin : g_tiles
        assign tiles[COLS*s +: COLS] = r_slot[s];
    end

    assign bottom_slot = r_bottom;
    assign score       = r_score;
    assign game_over   = r_over;
    assign miss        = r_miss;
    assign o_dbg_fsm   = r_fsm;

endmodule

// File: tb/tb_tile_pattern_gen.sv
// Randomized and directed bench for tile_pattern_gen against a rule-level game model.
import tile_pkg::*;

module tb_tile_pattern_gen;

    localparam int ROW_H     = 4;
    localparam int SCORE_MAX = 3;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic        scroll_tick;
    logic [2:0]  key;
    logic [14:0] tiles;
    logic [2:0]  bottom_slot;
    logic [9:0]  score;
    logic        game_over;
    logic        miss;
    fsm_t        dbg_fsm;

    tile_pattern_gen #(.ROW_H(ROW_H), .LFSR_SEED(SEED), .SCORE_MAX(SCORE_MAX)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .state       (state),
        .scroll_tick (scroll_tick),
        .key         (key),
        .tiles       (tiles),
        .bottom_slot (bottom_slot),
        .score       (score),
        .game_over   (game_over),
        .miss        (miss),
        .o_dbg_fsm   (dbg_fsm)
    );

    // clock / reset / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish before 2ms");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (game rules, plain variables) ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_OVER = 3;
    int         m_mode, m_k, m_tick, m_bottom, m_score;
    logic [2:0] m_slot [5];
    logic       m_over, m_miss;
    logic [7:0] m_lfsr;

    logic [29:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        // taps at exponents 8,6,5,4 -> register bits 7,5,4,3
        return {v[6:0], ^(v & 8'b1011_1000)};
    endfunction

    function automatic logic [2:0] pat_of(input logic [7:0] v);
        if (v[1:0] == 2'b11) return 3'b010;
        return 3'b001 << v[1:0];
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_k = 0; m_tick = 0; m_bottom = 0; m_score = 0;
        for (int s = 0; s < 5; s++) m_slot[s] = 3'b000;
        m_over = 1'b0; m_miss = 1'b0; m_lfsr = SEED;
    endtask

    task automatic model_edge(input logic [2:0] st, input logic tk, input logic [2:0] ky);
        logic [2:0] pat;
        logic       hit;
        pat    = pat_of(m_lfsr);
        m_miss = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (st == 3'b001) begin m_mode = M_LOAD; m_k = 0; end
            end
            M_LOAD: begin
                m_slot[m_k] = pat;
                m_score = 0; m_tick = 0; m_bottom = 0;
                m_k++;
                if (m_k == 5) m_mode = M_RUN;
            end
            M_RUN: begin
                if (st == 3'b000) begin
                    m_mode = M_IDLE;
                    for (int s = 0; s < 5; s++) m_slot[s] = 3'b000;
                end else if (st == 3'b001) begin
                    hit = (ky != 0) && (ky == m_slot[m_bottom]);
                    if (ky != 0 && !hit) m_miss = 1'b1;
                    else begin
                        if (hit) begin
                            m_slot[m_bottom] = 3'b000;
                            m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
                        end
                        if (tk) begin
                            m_tick++;
                            if (m_tick == ROW_H) begin
                                if (m_slot[m_bottom] != 0) m_miss = 1'b1;
                                else begin
                                    m_slot[m_bottom] = pat;
                                    m_bottom = (m_bottom + 1) % 5;
                                    m_tick = 0;
                                end
                            end
                        end
                    end
                    if (m_miss) begin m_over = 1'b1; m_mode = M_OVER; end
                end
            end
            default: begin
                if (st == 3'b000) begin
                    m_mode = M_IDLE; m_over = 1'b0;
                    for (int s = 0; s < 5; s++) m_slot[s] = 3'b000;
                end
            end
        endcase
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_expect();
        logic [14:0] t;
        for (int s = 0; s < 5; s++) t[3*s +: 3] = m_slot[s];
        exp_q.push_back({t, 3'(m_bottom), 10'(m_score), m_over, m_miss});
    endtask

    task automatic compare_outputs(input string tag);
        logic [29:0] e;
        e = exp_q.pop_front();
        check_eq({tag, ".tiles"},     32'(tiles),       32'(e[29:15]));
        check_eq({tag, ".bottom"},    32'(bottom_slot), 32'(e[14:12]));
        check_eq({tag, ".score"},     32'(score),       32'(e[11:2]));
        check_eq({tag, ".game_over"}, 32'(game_over),   32'(e[1]));
        check_eq({tag, ".miss"},      32'(miss),        32'(e[0]));
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic [2:0] st, input logic tk, input logic [2:0] ky);
        state = st; scroll_tick = tk; key = ky;
        @(posedge clk);
        model_edge(st, tk, ky);
        push_expect();
        #1;
        compare_outputs(tag);
    endtask

    function automatic logic [2:0] good_key();
        return m_slot[m_bottom];
    endfunction

    task automatic start_game(input string tag);
        step({tag, ".idle"}, 3'b000, 1'b0, 3'b000);
        step({tag, ".go"},   3'b001, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) step({tag, ".load"}, 3'b001, 1'b0, 3'b000);
        check_eq({tag, ".fsm_run"}, 32'(dbg_fsm), 32'(FSM_RUN));
    endtask

    task automatic coincident_hit(input string tag);
        for (int i = 0; i < ROW_H - 1; i++) step({tag, ".tick"}, 3'b001, 1'b1, 3'b000);
        step({tag, ".hit"}, 3'b001, 1'b1, good_key());
    endtask

    initial begin
        logic [2:0] k, b;
        logic [9:0] sc;
        rst_n = 1'b0; state = 3'b000; scroll_tick = 1'b0; key = 3'b000;
        model_reset();
        #12;
        push_expect();
        compare_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // load: every slot one-hot and matching the LFSR model
        start_game("load");
        for (int s = 0; s < 5; s++) check_eq("load.onehot", 32'($countones(tiles[3*s +: 3])), 32'd1);

        // correct key on slot 0, then scroll it off
        step("hit0", 3'b001, 1'b0, good_key());
        check_eq("hit0.cleared", 32'(tiles[2:0]), 32'd0);
        check_eq("hit0.score", 32'(score), 32'd1);
        for (int i = 0; i < ROW_H; i++) step("hit0.scroll", 3'b001, 1'b1, 3'b000);
        check_eq("hit0.bottom", 32'(bottom_slot), 32'd1);
        check_eq("hit0.refill", 32'($countones(tiles[2:0])), 32'd1);

        // freeze in stop state
        b = bottom_slot; sc = score;
        for (int i = 0; i < 6; i++) step("freeze", 3'b010, 1'b1, 3'($urandom_range(0, 7)));
        check_eq("freeze.bottom", 32'(bottom_slot), 32'(b));
        check_eq("freeze.score", 32'(score), 32'(sc));

        // coincident hit with the exit tick, then a second hit -> score 2, then reset mid-run
        coincident_hit("coinc");
        check_eq("coinc.bottom", 32'(bottom_slot), 32'd2);
        check_eq("coinc.nomiss", 32'(game_over), 32'd0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        push_expect();
        compare_outputs("rst_mid");
        @(posedge clk); #1 rst_n = 1'b1;

        // wrong column -> one-cycle miss, then everything ignored until idle
        start_game("wrong");
        k = good_key();
        step("wrong.key", 3'b001, 1'b0, {k[1:0], k[2]});
        check_eq("wrong.miss", 32'(miss), 32'd1);
        for (int i = 0; i < 5; i++) step("wrong.over", 3'b001, 1'b1, 3'($urandom_range(1, 7)));
        check_eq("wrong.pulse", 32'(miss), 32'd0);
        step("wrong.idle", 3'b000, 1'b0, 3'b000);
        check_eq("wrong.tiles0", 32'(tiles), 32'd0);

        // extra bits -> miss
        start_game("extra");
        step("extra.key", 3'b001, 1'b0, 3'b011);
        check_eq("extra.over", 32'(game_over), 32'd1);

        // timeout on a black bottom tile
        start_game("tmo");
        for (int i = 0; i < ROW_H; i++) step("tmo.tick", 3'b001, 1'b1, 3'b000);
        check_eq("tmo.miss", 32'(miss), 32'd1);
        check_eq("tmo.bottom", 32'(bottom_slot), 32'd0);
        check_eq("tmo.norefill", 32'($countones(tiles[2:0])), 32'd1);

        // four consecutive hits saturate the score
        start_game("sat");
        for (int r = 0; r < 4; r++) coincident_hit("sat");
        check_eq("sat.score", 32'(score), 32'(SCORE_MAX));

        // random play against the model
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] st, ky;
            int r;
            r  = int'($urandom_range(0, 99));
            st = (m_mode == M_OVER) ? 3'b000 :
                 (r < 3) ? 3'(2 + $urandom_range(0, 3)) :
                 (r < 4) ? 3'b000 : 3'b001;
            r  = int'($urandom_range(0, 99));
            ky = (r < 12) ? good_key() : (r < 14) ? 3'($urandom_range(1, 7)) : 3'b000;
            step("rand", st, 1'($urandom_range(0, 1)), ky);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
